branch_redirect_fetch_control: RTL
==================================

# branch_redirect_fetch_control

- Fetch-side consumer of the ID-stage branch decision in the MIPS32 pipeline.
- Owns the program counter:
  - advances it by 4 on each accepted fetch;
  - redirects it to the branch target when the ID-stage comparator resolves a taken branch;
  - squashes the wrong-path instruction in IF/ID.
- Holds a pending redirect while instruction memory is not ready.
- Sits between the ID-stage branch comparator and the IF stage / IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INCREMENT, 4, sequential fetch stride in bytes.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- check_for_branch  input  1  ID stage holds a branch instruction this cycle.
- branch_decision  input  1  comparator result; meaningful only when check_for_branch=1.
- branch_target  input  32  branch target address from ID.
- hazard_stall  input  1  load-use stall; freezes PC and IF/ID.
- imem_ready  input  1  instruction memory accepts the address on pc this cycle.
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc + PC_INCREMENT (combinational).
- if_id_flush  output  1  clear IF/ID at the next edge (combinational).
- if_id_write  output  1  enable IF/ID load (combinational).
- redirect_pending  output  1  high in REDIRECT_WAIT (registered state decode).

## Operation
- States: FETCH, REDIRECT_WAIT.
- take = check_for_branch & branch_decision & ~hazard_stall, evaluated only in FETCH.
- FETCH, take=1:
  - if_id_flush=1.
  - If imem_ready=1: pc <= {branch_target[31:2],2'b00}; stay in FETCH.
  - Else: latch the aligned target into target_buf; go to REDIRECT_WAIT; pc holds.
- FETCH, take=0:
  - If imem_ready & ~hazard_stall: pc <= pc_plus4.
  - Otherwise pc holds.
- REDIRECT_WAIT:
  - if_id_flush=1 every cycle.
  - Branch inputs and hazard_stall are ignored.
  - When imem_ready=1: pc <= target_buf; go to FETCH.
- if_id_write = imem_ready & ~hazard_stall & ~reset.
- hazard_stall with a branch in ID:
  - Decision ignored (operands may be stale); no flush; pc holds.
  - Resolution happens in the first unstalled cycle.
- Arithmetic:
  - pc_plus4 is 32-bit modulo (32'hFFFF_FFFC -> 32'h0).
  - Target bits [1:0] are forced to 0.
- Reset:
  - pc=RESET_PC, state=FETCH, redirect_pending=0, target_buf=0.
  - While reset is high: if_id_flush=1, if_id_write=0.
  - Reset during REDIRECT_WAIT discards the pending target.

## Timing
- Sequential advance: pc updates one edge after an accepted fetch.
- Taken redirect with imem_ready=1:
  - Target appears on pc at the next edge.
  - Exactly one wrong-path instruction is squashed (1-cycle penalty).
- Redirect under imem_ready=0:
  - Penalty is 1 + number of not-ready cycles.
  - redirect_pending rises the edge after the taken cycle and falls on the edge that loads the target.
- Combinational path: branch_decision -> if_id_flush. The team accepts this path; no register on it.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs branch_count[31:0] and taken_count[31:0], both reset to 0.
  - branch_count increments on each resolved branch (FETCH & check_for_branch & ~hazard_stall).
  - taken_count increments on each take.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package mips_fetch_pkg holds:
  - fetch_state_t enum {FETCH, REDIRECT_WAIT};
  - PC width constant;
  - default RESET_PC and PC_INCREMENT.
- Sub-module branch_stat_counter (saturating 32-bit counter with enable), instantiated twice only under BRANCH_STATS_EN.

## Test plan
- Reset, then imem_ready=1 with no branches -> pc 0x0, 0x4, 0x8 on successive edges; if_id_flush=0.
- pc=0x10, check_for_branch=1, branch_decision=1, target=0x40, imem_ready=1 -> if_id_flush=1 that cycle; pc=0x40, then 0x44.
- Same branch with imem_ready=0 for 2 cycles:
  - redirect_pending=1 and pc=0x10 held, flush high throughout.
  - imem_ready=1 -> pc=0x40; redirect_pending=0.
- hazard_stall=1 with a taken branch for 2 cycles -> pc held, flush=0, if_id_write=0; stall drops -> flush=1, pc=target next edge.
- Boundaries:
  - pc=0xFFFF_FFFC not-taken -> pc=0x0.
  - Taken target 0x43 -> pc=0x40.
  - check_for_branch=1, branch_decision=0 -> pc+4, no flush.
- Reset asserted in REDIRECT_WAIT -> pc=RESET_PC, redirect_pending=0; old target never loaded.
- With BRANCH_STATS_EN: 3 branches (2 taken) -> branch_count=3, taken_count=2.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared fetch-side types and constants for the MIPS32 IF stage.
package mips_fetch_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] DEFAULT_RESET_PC     = 32'h0000_0000;
   localparam logic [PC_W-1:0] DEFAULT_PC_INCREMENT = 32'd4;

   typedef enum logic {
      FETCH         = 1'b0,
      REDIRECT_WAIT = 1'b1
   } fetch_state_t;

   // Instruction fetches are word aligned; the low byte-offset bits are dropped.
   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/branch_stat_counter.sv
// Saturating 32-bit event counter with enable and synchronous reset.
module branch_stat_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 32'h0;
      end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/branch_redirect_fetch_control.sv
// PC owner for the IF stage: sequential advance, ID-resolved branch redirect, wrong-path squash.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_fetch_control
   import mips_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter logic [PC_W-1:0] PC_INCREMENT = DEFAULT_PC_INCREMENT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            check_for_branch,
   input  logic            branch_decision,
   input  logic [PC_W-1:0] branch_target,
   input  logic            hazard_stall,
   input  logic            imem_ready,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus4,
   output logic            if_id_flush,
   output logic            if_id_write,
`ifdef BRANCH_STATS_EN
   output logic [31:0]     branch_count,
   output logic [31:0]     taken_count,
`endif
   output logic            redirect_pending
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] target_buf_q, target_buf_d;
   logic            resolved;
   logic            take;

   // A stalled branch may see stale operands, so it only resolves once the stall drops.
   assign resolved = (state_q == FETCH) && check_for_branch && !hazard_stall;
   assign take     = resolved && branch_decision;

   assign pc_plus4 = pc_q + PC_INCREMENT;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         target_buf_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         target_buf_q <= target_buf_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      target_buf_d = target_buf_q;
      if_id_flush  = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (take) begin
               if_id_flush = 1'b1;
               if (imem_ready) begin
                  pc_d = word_align(branch_target);
               end else begin
                  target_buf_d = word_align(branch_target);
                  state_d      = REDIRECT_WAIT;
               end
            end else if (imem_ready && !hazard_stall) begin
               pc_d = pc_plus4;
            end
         end
         REDIRECT_WAIT: begin
            if_id_flush = 1'b1;
            if (imem_ready) begin
               pc_d    = target_buf_q;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
      if (reset) begin
         if_id_flush = 1'b1;
      end
   end

   assign pc               = pc_q;
   assign if_id_write      = imem_ready && !hazard_stall && !reset;
   assign redirect_pending = (state_q == REDIRECT_WAIT);

`ifdef BRANCH_STATS_EN
   branch_stat_counter u_branch_cnt (
      .clk     (clk),
      .reset   (reset),
      .en_i    (resolved),
      .count_o (branch_count)
   );

   branch_stat_counter u_taken_cnt (
      .clk     (clk),
      .reset   (reset),
      .en_i    (take),
      .count_o (taken_count)
   );
`endif

endmodule
